// File: rtl/clint_multi.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip,
// registered mtip, single-cycle-ack MMIO slave.
module clint_multi #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int unsigned NUM_HARTS  = 1,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic [31:0]          rdata,
  output logic                 ack,
  output logic                 err,
  output logic [NUM_HARTS-1:0] msip,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [63:0]          mtime_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP,
    SEL_MTIME
  } sel_e;

  logic [63:0]          mtime_q, mtime_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d;
  logic [63:0]          cmp_q [NUM_HARTS];
  logic [63:0]          cmp_d [NUM_HARTS];
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;

  sel_e        sel;
  logic [2:0]  hart_idx;
  logic        hi_half;
  logic [31:0] rd_val;
  logic        wr;
  logic        tick;
  logic        mtime_wr;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Window hit plus alignment, then per-region hart-range check.
  always_comb begin
    sel      = SEL_NONE;
    hart_idx = '0;
    hi_half  = addr[2];
    if (addr[31:16] == CLINT_BASE[31:16] && addr[1:0] == 2'b00) begin
      if (addr[15:14] == 2'b00 && 32'(addr[13:2]) < NUM_HARTS) begin
        sel      = SEL_MSIP;
        hart_idx = addr[4:2];
      end else if (addr[15:14] == 2'b01 && 32'(addr[13:3]) < NUM_HARTS) begin
        sel      = SEL_CMP;
        hart_idx = addr[5:3];
      end else if (addr[15:3] == 13'h17FF) begin
        sel = SEL_MTIME;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_MSIP: begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (32'(hart_idx) == h) rd_val = {31'd0, msip_q[h]};
        end
      end
      SEL_CMP: begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (32'(hart_idx) == h) rd_val = hi_half ? cmp_q[h][63:32] : cmp_q[h][31:0];
        end
      end
      SEL_MTIME: rd_val = hi_half ? mtime_q[63:32] : mtime_q[31:0];
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    wr       = req && we;
    tick     = (presc_q == PW'(TICK_DIV - 1));
    mtime_wr = wr && (sel == SEL_MTIME) && (wstrb != 4'b0000);

    presc_d = tick ? '0 : presc_q + PW'(1);
    ack_d   = req;
    err_d   = req && (sel == SEL_NONE);
    rdata_d = req ? rd_val : rdata_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    mtip_d  = mtip_q;
    mtime_d = mtime_q;

    // A bus write to mtime replaces the increment for that cycle entirely.
    if (mtime_wr) begin
      if (hi_half) mtime_d[63:32] = byte_merge(mtime_q[63:32], wdata, wstrb);
      else         mtime_d[31:0]  = byte_merge(mtime_q[31:0],  wdata, wstrb);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
      if (wr && sel == SEL_MSIP && 32'(hart_idx) == h && wstrb[0]) begin
        msip_d[h] = wdata[0];
      end
      if (wr && sel == SEL_CMP && 32'(hart_idx) == h) begin
        if (hi_half) cmp_d[h][63:32] = byte_merge(cmp_q[h][63:32], wdata, wstrb);
        else         cmp_d[h][31:0]  = byte_merge(cmp_q[h][31:0],  wdata, wstrb);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      presc_q <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      cmp_q   <= '{default: '1};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      cmp_q   <= cmp_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign msip    = msip_q;
  assign mtip    = mtip_q;
  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: a 2-hart TICK_DIV=1 instance against a transaction-level
// model, plus a 1-hart TICK_DIV=4 instance against an edge-count model.
module tb_clint_multi;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int NH = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack, err;
  logic [1:0]  msip, mtip;
  logic [63:0] mtime_o;

  logic        rst4, req4, we4;
  logic [31:0] addr4, wdata4;
  logic [3:0]  wstrb4;
  logic [31:0] rdata4;
  logic        ack4, err4;
  logic [0:0]  msip4, mtip4;
  logic [63:0] mtime4;

  clint_multi #(.CLINT_BASE(BASE), .NUM_HARTS(2), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ack(ack), .err(err), .msip(msip),
    .mtip(mtip), .mtime_o(mtime_o)
  );

  clint_multi #(.CLINT_BASE(BASE), .NUM_HARTS(1), .TICK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst4), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .wstrb(wstrb4), .rdata(rdata4), .ack(ack4), .err(err4), .msip(msip4),
    .mtip(mtip4), .mtime_o(mtime4)
  );

  // Reference state for the main instance
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [NH];
  logic [1:0]  m_msip, m_mtip;
  logic        m_ack, m_err, m_rd;
  logic [31:0] m_rdata;

  // Reference state for the divided instance
  int unsigned d4_edges;
  logic [63:0] d4_val;
  logic        d4_ack;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  task automatic decode(input logic [31:0] a, output int kind, output int hart, output int half);
    logic [31:0] off;
    off  = a - BASE;
    kind = 0;
    hart = 0;
    half = 0;
    if ((a >> 16) == (BASE >> 16) && (a % 4) == 0) begin
      if (off < 32'(4 * NH)) begin
        kind = 1;
        hart = int'(off / 4);
      end else if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * NH)) begin
        kind = 2;
        hart = int'((off - 32'h4000) / 8);
        half = int'((off % 8) / 4);
      end else if (off == 32'hBFF8 || off == 32'hBFFC) begin
        kind = 3;
        half = (off == 32'hBFFC) ? 1 : 0;
      end
    end
  endtask

  task automatic model_edge();
    int kind, hart, half;
    logic [1:0]  nxt;
    logic [31:0] val;
    logic [63:0] tmp;
    if (rst) begin
      m_mtime = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      m_msip = '0; m_mtip = '0;
      m_ack = 1'b0; m_err = 1'b0; m_rd = 1'b0; m_rdata = '0;
    end else begin
      decode(addr, kind, hart, half);
      for (int h = 0; h < NH; h++) nxt[h] = (m_mtime >= m_cmp[h]);
      case (kind)
        1: val = {31'd0, m_msip[hart]};
        2: val = (half != 0) ? m_cmp[hart][63:32] : m_cmp[hart][31:0];
        3: val = (half != 0) ? m_mtime[63:32] : m_mtime[31:0];
        default: val = '0;
      endcase
      m_ack = req;
      m_err = req && (kind == 0);
      m_rd  = req && !we;
      if (m_rd) m_rdata = val;
      if (req && we && kind == 3 && wstrb != 4'b0000) begin
        tmp = m_mtime;
        if (half != 0) tmp[63:32] = bmerge(tmp[63:32], wdata, wstrb);
        else           tmp[31:0]  = bmerge(tmp[31:0],  wdata, wstrb);
        m_mtime = tmp;
      end else begin
        m_mtime = m_mtime + 64'd1;
      end
      if (req && we && kind == 1 && wstrb[0]) m_msip[hart] = wdata[0];
      if (req && we && kind == 2) begin
        tmp = m_cmp[hart];
        if (half != 0) tmp[63:32] = bmerge(tmp[63:32], wdata, wstrb);
        else           tmp[31:0]  = bmerge(tmp[31:0],  wdata, wstrb);
        m_cmp[hart] = tmp;
      end
      m_mtip = nxt;
    end
  endtask

  task automatic d4_edge();
    if (rst4) begin
      d4_edges = 0;
      d4_val   = '0;
      d4_ack   = 1'b0;
    end else begin
      d4_edges++;
      d4_ack = req4;
      if (req4 && we4 && addr4 == BASE + 32'hBFF8 && wstrb4 == 4'hF)
        d4_val = {d4_val[63:32], wdata4};
      else if (d4_edges % 4 == 0)
        d4_val = d4_val + 64'd1;
    end
  endtask

  task automatic step();
    model_edge();
    d4_edge();
    @(posedge clk);
    #1;
    chk("ack", {63'd0, ack}, {63'd0, m_ack});
    chk("mtime_o", mtime_o, m_mtime);
    chk("mtip", {62'd0, mtip}, {62'd0, m_mtip});
    chk("msip", {62'd0, msip}, {62'd0, m_msip});
    if (m_ack || rst) chk("err", {63'd0, err}, {63'd0, m_err});
    if (m_rd || rst)  chk("rdata", {32'd0, rdata}, {32'd0, m_rdata});
    chk("d4_mtime", mtime4, d4_val);
    chk("d4_ack", {63'd0, ack4}, {63'd0, d4_ack});
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    repeat (n) step();
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic access4(input logic w, input logic [31:0] a, input logic [31:0] d);
    req4 = 1'b1; we4 = w; addr4 = a; wdata4 = d; wstrb4 = 4'hF;
    step();
    req4 = 1'b0; we4 = 1'b0;
  endtask

  logic [31:0] addr_tbl [14];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    rst4 = 1'b1; req4 = 1'b0; we4 = 1'b0; addr4 = '0; wdata4 = '0; wstrb4 = '0;
    step();
    step();
    rst = 1'b0; rst4 = 1'b0;

    // Idle from reset: 10 ticks at full rate, divided instance at 17 edges -> 4
    idle(10);
    chk("idle10_mtime", mtime_o, 64'd10);
    idle(7);
    chk("d4_after17", mtime4, 64'd4);
    access4(1'b0, BASE + 32'hBFF8, 32'd0);
    chk("d4_read_ack", {63'd0, ack4}, 64'd1);
    chk("d4_read_err", {63'd0, err4}, 64'd0);
    chk("d4_read_data", {32'd0, rdata4}, 64'd4);
    // mtime writes on and off a tick edge; the prescaler keeps its phase
    idle(1);
    access4(1'b1, BASE + 32'hBFF8, 32'd1000);
    idle(1);
    access4(1'b1, BASE + 32'hBFF8, 32'd2000);
    idle(2);
    chk("d4_phase", mtime4, 64'd2001);
    idle(4);
    chk("d4_phase2", mtime4, 64'd2002);

    // 64-bit carry and wrap
    access(1'b1, BASE + 32'hBFFC, 32'h0, 4'hF);
    access(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    idle(2);
    chk("carry", mtime_o, 64'h1_0000_0000);
    access(1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    access(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    chk("all_ones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    chk("wrap", mtime_o, 64'd0);

    // mtimecmp[1] crossing
    access(1'b1, BASE + 32'hBFFC, 32'h0, 4'hF);
    access(1'b1, BASE + 32'hBFF8, 32'd88, 4'hF);
    access(1'b1, BASE + 32'h4008, 32'd100, 4'hF);
    access(1'b1, BASE + 32'h400C, 32'd0, 4'hF);
    chk("cmp_mtime90", mtime_o, 64'd90);
    idle(10);
    chk("mtip_pre", {62'd0, mtip}, 64'd0);
    idle(1);
    chk("mtip_set", {62'd0, mtip}, 64'd2);
    access(1'b1, BASE + 32'h400C, 32'd1, 4'hF);
    chk("mtip_hold", {62'd0, mtip}, 64'd2);
    idle(1);
    chk("mtip_clr", {62'd0, mtip}, 64'd0);

    // msip byte enables
    access(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'b0001);
    chk("msip_set", {62'd0, msip}, 64'd2);
    access(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    chk("msip_read", {32'd0, rdata}, 64'd1);
    access(1'b1, BASE + 32'h4, 32'h0, 4'b0010);
    chk("msip_keep", {62'd0, msip}, 64'd2);
    access(1'b1, BASE + 32'hBFF8, 32'h0, 4'b0000);

    // Unmapped accesses
    access(1'b0, BASE + 32'h8, 32'h0, 4'h0);
    access(1'b0, BASE + 32'hBFF9, 32'h0, 4'h0);
    access(1'b0, BASE + 32'h1000, 32'h0, 4'h0);
    access(1'b0, 32'h0300_BFF8, 32'h0, 4'h0);
    access(1'b1, BASE + 32'h4010, 32'h1234_5678, 4'hF);
    access(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);

    // Reset the cycle after a req, then reset together with a req
    req = 1'b1; we = 1'b0; addr = BASE + 32'hBFF8;
    step();
    req = 1'b0; rst = 1'b1;
    step();
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_mtime", mtime_o, 64'd0);
    rst = 1'b0;
    idle(3);
    req = 1'b1; rst = 1'b1;
    step();
    chk("rst_req_ack", {63'd0, ack}, 64'd0);
    req = 1'b0; rst = 1'b0;
    idle(2);

    // Randomized traffic
    addr_tbl = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h4000, BASE + 32'h4004,
                 BASE + 32'h4008, BASE + 32'h400C, BASE + 32'h4010, BASE + 32'hBFF8,
                 BASE + 32'hBFFC, BASE + 32'hBFF9, BASE + 32'h1000, BASE + 32'h4002,
                 32'h0201_4000};
    for (int i = 0; i < 700; i++) begin
      int unsigned r;
      logic [31:0] a, d;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        req = ($urandom_range(0, 1) == 1);
        step();
        rst = 1'b0; req = 1'b0;
      end else if (r < 35) begin
        idle(1);
      end else begin
        a = ($urandom_range(0, 9) == 0) ? $urandom : addr_tbl[$urandom_range(0, 13)];
        case ($urandom_range(0, 2))
          0: d = $urandom;
          1: d = m_mtime[31:0] + 32'($urandom_range(0, 20));
          default: d = m_mtime[63:32];
        endcase
        access(($urandom_range(0, 1) == 1), a, d, 4'($urandom_range(0, 15)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
